scene_sequencer: RTL and testbench

- Per-pixel control sequencer for the ray tracer; replaces the fixed two-state reset/write toggle with a parametrised multi-sphere walk.
- For each (WriteX, WriteY): waits for the ray LUTs to settle, then presents every sphere index in turn to the shared collision unit.
- Tracks the nearest hit (best t and its sphere index), then issues one frame-buffer write with a ready/valid handshake and advances the raster.
- Sits between the x/y angle LUT + ray LUT chain, the collision unit, the sphere register file, the colour mapper and the frame buffer.

---
 rtl/rt_pkg.sv | 34 +++
 rtl/scene_sequencer_raster_counter.sv | 44 ++++
 rtl/scene_sequencer.sv | 159 +++++++++++++++
 tb/tb_scene_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared ray-tracer package.
// Holds the 32.32 fixed-point type, the vector and colour types, the default
// scene constants, and the scene_sequencer state encoding.
package rt_pkg;

    // Unsigned 32.32 fixed-point value.
    typedef logic [63:0] fixed_real;

    typedef struct packed {
        fixed_real x;
        fixed_real y;
        fixed_real z;
    } vector;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color;

    // Starting "best t" for every pixel. Any hit at or beyond this distance never wins.
    localparam fixed_real T_MAX_DEFAULT = 64'h8FFF_FFFF_0000_0000;
    localparam int        H_RES_DEFAULT = 640;
    localparam int        V_RES_DEFAULT = 480;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE
    } seq_state_t;

endpackage

// File: rtl/scene_sequencer_raster_counter.sv
// raster_counter: holds the current pixel coordinate and steps it in raster order.
//   clk, srst : clock and synchronous active-high reset (which returns the coordinate to 0,0)
//   advance   : step to the next pixel this cycle
//   x, y      : current column and row
//   last      : the current pixel is the final pixel of the frame (H_RES-1, V_RES-1)
module raster_counter
    import rt_pkg::*;
#(
    parameter int H_RES = H_RES_DEFAULT,
    parameter int V_RES = V_RES_DEFAULT
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       advance,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       last
);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    logic [9:0] x_reg;
    logic [9:0] y_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (advance) begin
            if (x_reg == X_LAST) begin
                x_reg <= '0;
                y_reg <= (y_reg == Y_LAST) ? 10'd0 : y_reg + 10'd1;
            end else begin
                x_reg <= x_reg + 10'd1;
            end
        end
    end

    assign x    = x_reg;
    assign y    = y_reg;
    assign last = (x_reg == X_LAST) && (y_reg == Y_LAST);

endmodule

// File: rtl/scene_sequencer.sv
// scene_sequencer: per-pixel control sequencer for the ray tracer.
// For each pixel it first waits for the ray LUTs to settle. It then walks every
// sphere index through the shared collision unit and keeps the nearest hit.
// Finally it issues one ready/valid frame-buffer write and advances the raster.
//   Clk, Reset         : clock and synchronous active-high reset
//   Start, Continuous  : start a frame from idle / at end of frame, restart instead of going idle
//   SphereIdx, TBest   : sphere under test and current best t, sent to the collision unit
//   Collide, TNew      : hit result for SphereIdx, valid COLLIDE_LATENCY cycles after issue
//   WriteX, WriteY     : current pixel coordinate
//   HitAny, HitIdx     : nearest-hit result, valid while WritePixel=1
//   WritePixel, WriteReady : frame-buffer write handshake
//   Busy, FrameDone    : not idle / one-cycle pulse after the last pixel is accepted
module scene_sequencer
    import rt_pkg::*;
#(
    parameter int        NUM_SPHERES     = 4,
    parameter int        H_RES           = H_RES_DEFAULT,
    parameter int        V_RES           = V_RES_DEFAULT,
    parameter int        RAY_LATENCY     = 2,
    parameter int        COLLIDE_LATENCY = 1,
    parameter fixed_real T_MAX           = T_MAX_DEFAULT,
    localparam int       IDX_W           = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Continuous,
    output logic [IDX_W-1:0] SphereIdx,
    output logic [63:0]      TBest,
    input  logic             Collide,
    input  logic [63:0]      TNew,
    output logic [9:0]       WriteX,
    output logic [9:0]       WriteY,
    output logic             HitAny,
    output logic [IDX_W-1:0] HitIdx,
    output logic             WritePixel,
    input  logic             WriteReady,
    output logic             Busy,
    output logic             FrameDone
);

    // A single counter is shared by the SETUP and WAIT phases, so it is sized for the longer one.
    localparam int LAT_MAX = (RAY_LATENCY > COLLIDE_LATENCY) ? RAY_LATENCY : COLLIDE_LATENCY;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CNT_W-1:0] RAY_LAST     = CNT_W'(RAY_LATENCY - 1);
    localparam logic [CNT_W-1:0] COLLIDE_LAST = CNT_W'(COLLIDE_LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_SPHERES - 1);

    seq_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] sphere_reg;
    logic [63:0]      tbest_reg;
    logic             hit_any_reg;
    logic [IDX_W-1:0] hit_idx_reg;
    logic             write_pixel_reg;
    logic             frame_done_reg;

    logic advance;
    logic last_pixel;

    assign advance = (state_reg == ST_WRITE) && WriteReady;

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_raster (
        .clk     (Clk),
        .srst    (Reset),
        .advance (advance),
        .x       (WriteX),
        .y       (WriteY),
        .last    (last_pixel)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            sphere_reg      <= '0;
            tbest_reg       <= T_MAX;
            hit_any_reg     <= 1'b0;
            hit_idx_reg     <= '0;
            write_pixel_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        state_reg   <= ST_SETUP;
                        cnt_reg     <= '0;
                        sphere_reg  <= '0;
                        tbest_reg   <= T_MAX;
                        hit_any_reg <= 1'b0;
                        hit_idx_reg <= '0;
                    end
                end
                ST_SETUP: begin
                    if (cnt_reg == RAY_LAST) begin
                        state_reg <= ST_ISSUE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_reg <= ST_WAIT;
                    cnt_reg   <= '0;
                end
                ST_WAIT: begin
                    if (cnt_reg == COLLIDE_LAST) begin
                        // A strict compare means a tie keeps the earlier (lower) index.
                        // Because TBest starts at T_MAX, hits at or beyond T_MAX are dropped.
                        if (Collide && (TNew < tbest_reg)) begin
                            tbest_reg   <= TNew;
                            hit_idx_reg <= sphere_reg;
                            hit_any_reg <= 1'b1;
                        end
                        if (sphere_reg == IDX_LAST) begin
                            state_reg       <= ST_WRITE;
                            write_pixel_reg <= 1'b1;
                        end else begin
                            sphere_reg <= sphere_reg + 1'b1;
                            state_reg  <= ST_ISSUE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (WriteReady) begin
                        write_pixel_reg <= 1'b0;
                        cnt_reg         <= '0;
                        sphere_reg      <= '0;
                        tbest_reg       <= T_MAX;
                        hit_any_reg     <= 1'b0;
                        hit_idx_reg     <= '0;
                        if (last_pixel) begin
                            frame_done_reg <= 1'b1;
                            state_reg      <= Continuous ? ST_SETUP : ST_IDLE;
                        end else begin
                            state_reg <= ST_SETUP;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign SphereIdx  = sphere_reg;
    assign TBest      = tbest_reg;
    assign HitAny     = hit_any_reg;
    assign HitIdx     = hit_idx_reg;
    assign WritePixel = write_pixel_reg;
    assign FrameDone  = frame_done_reg;
    assign Busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed testbench for scene_sequencer.
// Two instances share the clock and reset:
//   u_one   : one sphere, used for the per-pixel latency case
//   u_three : three spheres, used for nearest-hit, stall, raster, frame and reset cases
// Both instances use a 4x2 raster, so a full frame is eight pixels.
module tb_scene_sequencer;

    localparam logic [63:0] TMAX = 64'h8FFF_FFFF_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Single-sphere instance
    logic        start1, cont1, coll1, ready1;
    logic [63:0] tnew1;
    logic [0:0]  sidx1, hidx1;
    logic [63:0] tbest1;
    logic [9:0]  wx1, wy1;
    logic        hany1, wp1, busy1, fd1;

    // Three-sphere instance
    logic        start3, cont3, ready3;
    logic        coll3;
    logic [63:0] tnew3;
    logic [1:0]  sidx3, hidx3;
    logic [63:0] tbest3;
    logic [9:0]  wx3, wy3;
    logic        hany3, wp3, busy3, fd3;

    // Collision responses for the three-sphere instance, looked up by sphere index
    logic        coll_tab [4];
    logic [63:0] tnew_tab [4];

    assign coll3 = coll_tab[sidx3];
    assign tnew3 = tnew_tab[sidx3];

    int checks = 0;
    int errors = 0;

    scene_sequencer #(
        .NUM_SPHERES(1), .H_RES(4), .V_RES(2), .RAY_LATENCY(2), .COLLIDE_LATENCY(1)
    ) u_one (
        .Clk(clk), .Reset(reset), .Start(start1), .Continuous(cont1),
        .SphereIdx(sidx1), .TBest(tbest1), .Collide(coll1), .TNew(tnew1),
        .WriteX(wx1), .WriteY(wy1), .HitAny(hany1), .HitIdx(hidx1),
        .WritePixel(wp1), .WriteReady(ready1), .Busy(busy1), .FrameDone(fd1)
    );

    scene_sequencer #(
        .NUM_SPHERES(3), .H_RES(4), .V_RES(2), .RAY_LATENCY(2), .COLLIDE_LATENCY(1)
    ) u_three (
        .Clk(clk), .Reset(reset), .Start(start3), .Continuous(cont3),
        .SphereIdx(sidx3), .TBest(tbest3), .Collide(coll3), .TNew(tnew3),
        .WriteX(wx3), .WriteY(wy3), .HitAny(hany3), .HitIdx(hidx3),
        .WritePixel(wp3), .WriteReady(ready3), .Busy(busy3), .FrameDone(fd3)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to the next negedge at which u_three presents WritePixel. The wait is
    // bounded, and running out of the bound counts as a failed comparison.
    task automatic wait_write3(input int bound);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (wp3) found = 1'b1;
        end
        check("write_timeout", 64'(found), 64'd1);
        $display("write: x=%0d y=%0d hit_any=%0d hit_idx=%0d tbest=%h", wx3, wy3, hany3, hidx3, tbest3);
    endtask

    task automatic set_tab(input logic c0, input logic [63:0] t0,
                           input logic c1, input logic [63:0] t1,
                           input logic c2, input logic [63:0] t2);
        coll_tab[0] = c0; tnew_tab[0] = t0;
        coll_tab[1] = c1; tnew_tab[1] = t1;
        coll_tab[2] = c2; tnew_tab[2] = t2;
        coll_tab[3] = 1'b0; tnew_tab[3] = TMAX;
    endtask

    initial begin
        logic saw_wp;
        reset = 1'b1;
        start1 = 1'b0; cont1 = 1'b0; coll1 = 1'b0; tnew1 = '0; ready1 = 1'b1;
        start3 = 1'b0; cont3 = 1'b0; ready3 = 1'b1;
        set_tab(1'b0, TMAX, 1'b0, TMAX, 1'b0, TMAX);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_wp",    64'(wp3), 64'd0);
        check("rst_busy",  64'(busy3), 64'd0);
        check("rst_tbest", tbest3, TMAX);
        check("rst_x",     64'(wx3), 64'd0);
        check("rst_y",     64'(wy3), 64'd0);
        check("rst_hany",  64'(hany3), 64'd0);
        check("rst_sidx",  64'(sidx3), 64'd0);
        check("rst_fd",    64'(fd3), 64'd0);

        // One sphere, no hit: WritePixel rises exactly 5 cycles after the Start cycle
        start1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start1 = 1'b0;
            if (k < 5) check($sformatf("lat_wp_low_%0d", k), 64'(wp1), 64'd0);
        end
        $display("latency: wp=%0d hit_any=%0d x=%0d", wp1, hany1, wx1);
        check("lat_wp_high", 64'(wp1), 64'd1);
        check("lat_hany",    64'(hany1), 64'd0);
        check("lat_busy",    64'(busy1), 64'd1);
        @(negedge clk);
        check("lat_x_adv",   64'(wx1), 64'd1);
        check("lat_wp_drop", 64'(wp1), 64'd0);

        // Three spheres: nearest hit is sphere 1
        set_tab(1'b1, 64'd10 << 32, 1'b1, 64'd4 << 32, 1'b1, 64'd7 << 32);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_write3(40);
        check("near_hany",  64'(hany3), 64'd1);
        check("near_hidx",  64'(hidx3), 64'd1);
        check("near_tbest", tbest3, 64'd4 << 32);
        check("near_x",     64'(wx3), 64'd0);
        check("near_y",     64'(wy3), 64'd0);

        // A tie between spheres 0 and 2 keeps index 0
        @(negedge clk);
        set_tab(1'b1, 64'd5 << 32, 1'b0, 64'd1 << 32, 1'b1, 64'd5 << 32);
        wait_write3(40);
        check("tie_hidx",  64'(hidx3), 64'd0);
        check("tie_hany",  64'(hany3), 64'd1);
        check("tie_tbest", tbest3, 64'd5 << 32);
        check("tie_x",     64'(wx3), 64'd1);

        // Collide is asserted for every sphere, but each TNew equals T_MAX, so there is no hit
        @(negedge clk);
        set_tab(1'b1, TMAX, 1'b1, TMAX, 1'b1, TMAX);
        wait_write3(40);
        check("tmax_hany",  64'(hany3), 64'd0);
        check("tmax_tbest", tbest3, TMAX);
        check("tmax_x",     64'(wx3), 64'd2);

        // Last sphere wins; WriteReady is held low for 3 cycles of WRITE
        @(negedge clk);
        set_tab(1'b1, 64'd9 << 32, 1'b1, 64'd8 << 32, 1'b1, 64'd3 << 32);
        ready3 = 1'b0;
        wait_write3(40);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_wp_%0d", i),   64'(wp3), 64'd1);
            check($sformatf("stall_x_%0d", i),    64'(wx3), 64'd3);
            check($sformatf("stall_y_%0d", i),    64'(wy3), 64'd0);
            check($sformatf("stall_hidx_%0d", i), 64'(hidx3), 64'd2);
            if (i == 3) ready3 = 1'b1;
            @(negedge clk);
        end
        check("stall_wp_drop", 64'(wp3), 64'd0);
        check("stall_x_wrap",  64'(wx3), 64'd0);
        check("stall_y_inc",   64'(wy3), 64'd1);

        // Finish the frame with Continuous=0
        set_tab(1'b0, TMAX, 1'b0, TMAX, 1'b0, TMAX);
        for (int p = 0; p < 4; p++) begin
            wait_write3(40);
            check($sformatf("row1_x_%0d", p), 64'(wx3), 64'(p));
            check($sformatf("row1_y_%0d", p), 64'(wy3), 64'd1);
        end
        @(negedge clk);
        check("fd_pulse",  64'(fd3), 64'd1);
        check("fd_idle",   64'(busy3), 64'd0);
        check("fd_x_wrap", 64'(wx3), 64'd0);
        check("fd_y_wrap", 64'(wy3), 64'd0);
        @(negedge clk);
        check("fd_once",   64'(fd3), 64'd0);
        check("idle_busy", 64'(busy3), 64'd0);

        // Continuous=1: the ninth write lands at (0,0) and the sequencer stays busy
        cont3 = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_write3(40);
            check($sformatf("cont_x_%0d", i), 64'(wx3), 64'(i % 4));
            check($sformatf("cont_y_%0d", i), 64'(wy3), 64'(i / 4));
        end
        @(negedge clk);
        check("cont_fd",   64'(fd3), 64'd1);
        check("cont_busy", 64'(busy3), 64'd1);
        wait_write3(40);
        check("cont_9_x", 64'(wx3), 64'd0);
        check("cont_9_y", 64'(wy3), 64'd0);

        // Run on to pixel (2,1), then assert reset while the sequencer is in WAIT
        cont3 = 1'b0;
        for (int i = 1; i <= 5; i++) wait_write3(40);
        check("pre_rst_x", 64'(wx3), 64'd1);
        check("pre_rst_y", 64'(wy3), 64'd1);
        // WRITE -> SETUP, SETUP, ISSUE, WAIT
        repeat (4) @(negedge clk);
        check("pre_rst_x2", 64'(wx3), 64'd2);
        check("pre_rst_wp", 64'(wp3), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("reset: busy=%0d wp=%0d x=%0d y=%0d tbest=%h", busy3, wp3, wx3, wy3, tbest3);
        check("mid_rst_busy",  64'(busy3), 64'd0);
        check("mid_rst_wp",    64'(wp3), 64'd0);
        check("mid_rst_x",     64'(wx3), 64'd0);
        check("mid_rst_y",     64'(wy3), 64'd0);
        check("mid_rst_tbest", tbest3, TMAX);
        check("mid_rst_hany",  64'(hany3), 64'd0);
        check("mid_rst_hidx",  64'(hidx3), 64'd0);
        check("mid_rst_sidx",  64'(sidx3), 64'd0);
        check("mid_rst_fd",    64'(fd3), 64'd0);
        saw_wp = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (wp3) saw_wp = 1'b1;
        end
        check("post_rst_no_write", 64'(saw_wp), 64'd0);
        check("post_rst_busy",     64'(busy3), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
